// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : apb_pkg
// Brief   : Shared APB widths, sequencer state type and default timeout.
// Rev     : 1.0  initial release
// ============================================================================
package apb_pkg;

    localparam int APB_ADDR_W      = 32;
    localparam int APB_DATA_W      = 32;
    localparam int TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin pick, searching upward from pointer+1.
// Rev     : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] pointer,
    input  logic          enable,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] index
);

    logic          w_found;
    logic [IW-1:0] w_cand;

    always_comb begin
        gnt     = '0;
        index   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        // Nearest candidate after the pointer wins; the pointer itself is tried last.
        for (int k = 1; k <= N; k++) begin
            w_cand = IW'((int'(pointer) + k) % N);
            if (enable && !w_found && req[w_cand]) begin
                w_found     = 1'b1;
                gnt[w_cand] = 1'b1;
                index       = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_rr_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : apb_rr_master_arbiter
// Brief   : Round-robin sharing of one APB master port with PREADY timeout.
// Rev     : 1.0  initial release
// ============================================================================
module apb_rr_master_arbiter
    import apb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                            PCLK,
    input  logic                            PRESET,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ*APB_ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*APB_DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [APB_DATA_W-1:0]           rsp_rdata,
    output logic                            rsp_err,
    output logic                            rsp_timeout,
    output logic                            PSEL,
    output logic                            PENABLE,
    output logic [APB_ADDR_W-1:0]           PADDR,
    output logic [APB_DATA_W-1:0]           PWDATA,
    output logic                            PWRITE,
    input  logic [APB_DATA_W-1:0]           PRDATA,
    input  logic                            PREADY,
    input  logic                            PSLVERR
);

    localparam int                IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int                CNT_W       = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  C_CNT_LIMIT = CNT_W'(TIMEOUT - 1);
    localparam logic [1:0]        C_ST_IDLE   = IDLE;
    localparam logic [1:0]        C_ST_SETUP  = SETUP;
    localparam logic [1:0]        C_ST_ACCESS = ACCESS;

    logic [1:0]             r_state;
    logic [IDX_W-1:0]       r_owner;
    logic [IDX_W-1:0]       r_ptr;
    logic [CNT_W-1:0]       r_cnt;

    logic                   w_arb_en;
    logic [NUM_REQ-1:0]     w_gnt;
    logic [IDX_W-1:0]       w_idx;
    logic [NUM_REQ-1:0]     w_owner_oh;

    // Gating with PRESET keeps req_ready low for the whole reset window.
    assign w_arb_en = (r_state == C_ST_IDLE) && !PRESET;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_rr_arbiter (
        .req     (req_valid),
        .pointer (r_ptr),
        .enable  (w_arb_en),
        .gnt     (w_gnt),
        .index   (w_idx)
    );

    assign req_ready = w_gnt;
    assign PSEL      = (r_state == C_ST_SETUP) || (r_state == C_ST_ACCESS);
    assign PENABLE   = (r_state == C_ST_ACCESS);

    always_comb begin
        w_owner_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_owner_oh[i] = (r_owner == IDX_W'(i));
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state     <= C_ST_IDLE;
            r_owner     <= '0;
            r_ptr       <= IDX_W'(NUM_REQ - 1);
            r_cnt       <= '0;
            PADDR       <= '0;
            PWDATA      <= '0;
            PWRITE      <= 1'b0;
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            case (r_state)
                C_ST_IDLE: begin
                    if (|w_gnt) begin
                        PADDR   <= req_addr[int'(w_idx)*APB_ADDR_W +: APB_ADDR_W];
                        PWDATA  <= req_wdata[int'(w_idx)*APB_DATA_W +: APB_DATA_W];
                        PWRITE  <= req_write[w_idx];
                        r_owner <= w_idx;
                        r_ptr   <= w_idx;
                        r_state <= C_ST_SETUP;
                    end
                end
                C_ST_SETUP: begin
                    r_cnt   <= '0;
                    r_state <= C_ST_ACCESS;
                end
                C_ST_ACCESS: begin
                    // A ready slave on the limit cycle still completes normally.
                    if (PREADY) begin
                        r_state   <= C_ST_IDLE;
                        rsp_valid <= w_owner_oh;
                        rsp_rdata <= PWRITE ? '0 : PRDATA;
                        rsp_err   <= PSLVERR;
                    end else if (r_cnt == C_CNT_LIMIT) begin
                        r_state     <= C_ST_IDLE;
                        rsp_valid   <= w_owner_oh;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                    end else if (r_cnt != {CNT_W{1'b1}}) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= C_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_rr_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_apb_rr_master_arbiter
// Brief   : Directed plus randomized bench for apb_rr_master_arbiter.
// Rev     : 1.0  initial release
// ============================================================================
module tb_apb_rr_master_arbiter;

    localparam int NUM = 4;
    localparam int TMO = 16;

    logic                PCLK = 1'b0;
    logic                PRESET;
    logic [NUM-1:0]      req_valid;
    logic [NUM-1:0]      req_write;
    logic [NUM*32-1:0]   req_addr;
    logic [NUM*32-1:0]   req_wdata;
    logic [NUM-1:0]      req_ready;
    logic [NUM-1:0]      rsp_valid;
    logic [31:0]         rsp_rdata;
    logic                rsp_err;
    logic                rsp_timeout;
    logic                PSEL;
    logic                PENABLE;
    logic [31:0]         PADDR;
    logic [31:0]         PWDATA;
    logic                PWRITE;
    logic [31:0]         PRDATA;
    logic                PREADY;
    logic                PSLVERR;

    logic [31:0]         addr_m  [NUM];
    logic [31:0]         wdata_m [NUM];
    logic                write_m [NUM];

    int n_tests = 0;
    int n_fail  = 0;
    int m_ptr   = NUM - 1;

    always #5 PCLK = ~PCLK;

    always_comb begin
        req_addr  = '0;
        req_wdata = '0;
        req_write = '0;
        for (int i = 0; i < NUM; i++) begin
            req_addr[i*32 +: 32]  = addr_m[i];
            req_wdata[i*32 +: 32] = wdata_m[i];
            req_write[i]          = write_m[i];
        end
    end

    apb_rr_master_arbiter #(
        .NUM_REQ (NUM),
        .TIMEOUT (TMO)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PWRITE      (PWRITE),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first requester after the last winner, wrapping.
    function automatic int pick(input logic [NUM-1:0] v, input int p);
        for (int k = 1; k <= NUM; k++) begin
            int c;
            c = (p + k) % NUM;
            if (((v >> c) & 1) != 0) return c;
        end
        return -1;
    endfunction

    function automatic logic [31:0] onehot(input int w);
        return 32'd1 << w;
    endfunction

    // Starts in an IDLE cycle with req_valid already driven; returns in the response cycle.
    task automatic xfer(input int waits, input logic slverr, input logic [31:0] prd, input bit hold);
        int          w;
        int          n_acc;
        bit          tmo;
        logic [31:0] e_rd;
        w = pick(req_valid, m_ptr);
        if (w < 0) return;
        #1;
        check("req_ready", req_ready, onehot(w));
        @(negedge PCLK);
        m_ptr = w;
        if (!hold) req_valid[w] = 1'b0;
        check("setup_sel_en", {PSEL, PENABLE}, 32'd2);
        check("setup_paddr",  PADDR,  addr_m[w]);
        check("setup_pwdata", PWDATA, wdata_m[w]);
        check("setup_pwrite", PWRITE, write_m[w]);
        check("rsp_cleared",  rsp_valid, 32'd0);
        tmo   = (waits >= TMO);
        n_acc = tmo ? TMO : waits + 1;
        PRDATA  = prd;
        PSLVERR = slverr;
        for (int k = 0; k < n_acc; k++) begin
            @(negedge PCLK);
            PREADY = (k >= waits);
            check("access_sel_en", {PSEL, PENABLE}, 32'd3);
            check("access_paddr",  PADDR, addr_m[w]);
        end
        @(negedge PCLK);
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = $urandom;
        e_rd = (tmo || write_m[w]) ? 32'd0 : prd;
        check("rsp_valid",   rsp_valid,   onehot(w));
        check("rsp_rdata",   rsp_rdata,   e_rd);
        check("rsp_err",     rsp_err,     tmo ? 1'b1 : slverr);
        check("rsp_timeout", rsp_timeout, tmo);
        check("rsp_idle",    {PSEL, PENABLE}, 32'd0);
    endtask

    initial begin
        PRESET    = 1'b1;
        req_valid = '1;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            addr_m[i]  = 32'h100 * (i + 1);
            wdata_m[i] = 32'hA000_0000 + i;
            write_m[i] = 1'b0;
        end

        // Reset state, with requests present to prove req_ready is suppressed.
        repeat (2) @(negedge PCLK);
        check("rst_sel_en",    {PSEL, PENABLE}, 32'd0);
        check("rst_req_ready", req_ready, 32'd0);
        check("rst_rsp_valid", rsp_valid, 32'd0);
        check("rst_paddr",     PADDR, 32'd0);
        check("rst_rsp_misc",  {rsp_err, rsp_timeout, rsp_rdata}, 32'd0);
        req_valid = '0;
        PRESET    = 1'b0;
        @(negedge PCLK);

        // Single zero-wait write from requester 0.
        addr_m[0] = 32'h1000; wdata_m[0] = 32'hDEAD_BEEF; write_m[0] = 1'b1;
        req_valid = 4'b0001;
        xfer(0, 1'b0, 32'h0, 1'b0);
        @(negedge PCLK);
        check("rsp_one_cycle", rsp_valid, 32'd0);

        // Read from requester 2 with two wait states.
        addr_m[2] = 32'h20; write_m[2] = 1'b0;
        req_valid = 4'b0100;
        xfer(2, 1'b0, 32'h1234_5678, 1'b0);

        // Continuous requests from everyone: back-to-back rotation.
        req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) xfer(0, 1'b0, 32'h5500_0000 + n, 1'b1);
        req_valid = '0;

        // Slave error on a write from requester 1.
        write_m[1] = 1'b1; addr_m[1] = 32'h44;
        @(negedge PCLK);
        req_valid = 4'b0010;
        xfer(0, 1'b1, 32'h0, 1'b0);

        // Timeout on requester 0 with requester 3 waiting behind it.
        write_m[0] = 1'b0;
        req_valid  = 4'b1001;
        m_ptr      = m_ptr;
        xfer(TMO + 3, 1'b0, 32'hCAFE_F00D, 1'b0);
        xfer(0, 1'b0, 32'h0BAD_0003, 1'b0);

        // Boundary: slave ready exactly on the timeout limit cycle.
        req_valid = 4'b0100;
        xfer(TMO - 1, 1'b0, 32'h7777_0002, 1'b0);

        // Asynchronous reset while in ACCESS.
        req_valid = 4'b0010;
        write_m[1] = 1'b0;
        #1;
        check("pre_rst_ready", req_ready, onehot(pick(req_valid, m_ptr)));
        @(negedge PCLK);
        @(negedge PCLK);
        PREADY = 1'b0;
        check("pre_rst_access", {PSEL, PENABLE}, 32'd3);
        #2;
        PRESET = 1'b1;
        #1;
        m_ptr = NUM - 1;
        check("arst_sel_en",    {PSEL, PENABLE}, 32'd0);
        check("arst_req_ready", req_ready, 32'd0);
        check("arst_rsp_valid", rsp_valid, 32'd0);
        @(negedge PCLK);
        PRESET    = 1'b0;
        req_valid = '0;
        @(negedge PCLK);
        check("post_rst_no_rsp", rsp_valid, 32'd0);
        check("post_rst_idle",   {PSEL, PENABLE}, 32'd0);
        req_valid = 4'b1111;
        xfer(0, 1'b0, 32'h0000_0AAA, 1'b0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 30; n++) begin
            int wt;
            for (int i = 0; i < NUM; i++) begin
                addr_m[i]  = $urandom;
                wdata_m[i] = $urandom;
                write_m[i] = 1'($urandom_range(0, 1));
            end
            req_valid = NUM'($urandom_range(1, (1 << NUM) - 1));
            wt = ($urandom_range(0, 9) == 0) ? TMO + $urandom_range(0, 3) : $urandom_range(0, 3);
            xfer(wt, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
        end
        req_valid = '0;
        @(negedge PCLK);
        check("final_idle", {PSEL, PENABLE, rsp_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_rr_master_arbiter.md
Name: apb_rr_master_arbiter

Overview:
- Shares one APB bus master port among NUM_REQ independent requesters (CPU bridge, DMA, debug).
- Contains a round-robin arbiter plus the APB IDLE/SETUP/ACCESS sequencer.
- Latches the winning request, runs one APB transfer, and routes the read data and error back to the winner.
- Adds a PREADY timeout so a hung slave cannot block the bus.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 16, maximum ACCESS cycles with PREADY low before forced termination (>=1).

Ports:
- PCLK  in  1  bus clock; all logic on the rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request; held until req_ready.
- req_write  in  NUM_REQ  per-requester direction (1 = write).
- req_addr  in  NUM_REQ*32  packed addresses; requester i at [32i+31:32i].
- req_wdata  in  NUM_REQ*32  packed write data.
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse to the owner.
- rsp_rdata  out  32  read data; valid with rsp_valid.
- rsp_err  out  1  PSLVERR or timeout; valid with rsp_valid.
- rsp_timeout  out  1  completion was a timeout; valid with rsp_valid.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PADDR  out  32  APB address.
- PWDATA  out  32  APB write data.
- PWRITE  out  1  APB direction.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

Behaviour:
- Reset: asynchronous, active-high. All outputs go to 0 immediately. State = IDLE, timeout counter = 0, round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
- Reset mid-transfer: the transfer is abandoned with no rsp_valid. The requester must re-issue.
- State IDLE: PSEL=0, PENABLE=0.
  - If any req_valid is high, the arbiter picks the first set bit searching from pointer+1 upward, wrapping modulo NUM_REQ.
  - req_ready[winner]=1 combinationally in this cycle.
  - On the edge: latch addr/wdata/write into PADDR/PWDATA/PWRITE, store owner index, pointer <= winner, go to SETUP.
  - If no request: stay in IDLE, hold PADDR/PWDATA/PWRITE at their last values.
- State SETUP: PSEL=1, PENABLE=0. Always go to ACCESS. Clear the timeout counter.
- State ACCESS: PSEL=1, PENABLE=1. PADDR/PWDATA/PWRITE stay stable.
  - PREADY=1: go to IDLE. Register rsp_rdata=PRDATA (reads only; writes give 0), rsp_err=PSLVERR, rsp_timeout=0, rsp_valid[owner]=1 for exactly the next cycle.
  - PREADY=0: increment the counter.
  - Counter reaches TIMEOUT-1 with PREADY still 0: go to IDLE, rsp_valid[owner]=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - PREADY=1 in the same cycle as the counter limit: normal completion wins.
- Latency with a zero-wait slave:
  - Accept at cycle T; SETUP at T+1; ACCESS at T+2.
  - rsp_valid at T+3, state IDLE at T+3.
  - Next grant at T+3 earliest, so the bus issues one transfer per 3 cycles.
- rsp_valid, rsp_rdata, rsp_err and rsp_timeout are registered and held at 0 outside the response cycle.
- A requester that drops req_valid before req_ready is simply not granted; no error.
- req_valid changes while the FSM is outside IDLE are ignored until the next IDLE cycle.
- NUM_REQ=1 degenerates to a single-owner sequencer; the pointer stays at 0.
- Counter width: $clog2(TIMEOUT+1); it saturates and never wraps.

Decomposition:
- Shared package apb_pkg holds:
  - apb_state_e {IDLE, SETUP, ACCESS} as logic [1:0];
  - localparams APB_ADDR_W=32 and APB_DATA_W=32;
  - default TIMEOUT constant.
- Sub-module rr_arbiter (parameter N):
  - inputs req[N], pointer, enable;
  - outputs one-hot gnt[N] and index.
  - Purely combinational; the pointer register lives in the top.

Test Plan:
- Single write, no wait: req0 addr=0x1000 wdata=0xDEADBEEF at T.
  -> req_ready[0] at T; PSEL=1/PENABLE=0 at T+1; PENABLE=1 at T+2 with PADDR=0x1000, PWRITE=1; rsp_valid=0001 at T+3, rsp_err=0.
- Read with 2 wait states: req2 read addr=0x20, PREADY low 2 ACCESS cycles, PRDATA=0x12345678.
  -> ACCESS lasts 3 cycles; rsp_valid=0100, rsp_rdata=0x12345678.
- Round-robin fairness: all 4 req_valid held high continuously.
  -> grant order 0,1,2,3,0; each req_ready 3 cycles apart.
- Slave error: req1 write, PREADY=1 and PSLVERR=1 in ACCESS.
  -> rsp_valid=0010, rsp_err=1, rsp_timeout=0.
- Timeout: TIMEOUT=16, PREADY held 0.
  -> after 16 ACCESS cycles: rsp_err=1, rsp_timeout=1, FSM back in IDLE, next pending request granted.
- Async reset mid-ACCESS: assert PRESET between edges.
  -> PSEL/PENABLE/req_ready/rsp_valid all 0 immediately, no rsp_valid pulse; after release requester 0 wins first.
